menu_controller: RTL and testbench

MENU_CONTROLLER -- requirements
Module: menu_controller

---
 rtl/menu_controller.sv | 198 +++++++++++++++++++
 tb/tb_menu_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/menu_controller.sv
// ---------------------------------------------------------------------------
// menu_controller
// Front-panel menu sequencer.
// The raw buttons are synchronised and debounced. Each press becomes one
// event, and the events drive a three-state menu (MENU / SETTING / GAME).
// The visible cursor and difficulty only update on frame_tick, so the
// picture never tears. While in MENU, the selected item blinks every
// BLINK_FRAMES frames.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   frame_tick    one-cycle pulse at start of vertical blank
//   btn_up/down/sel/back  raw asynchronous buttons, high = pressed
//   game_over     one-cycle pulse from the game core
//   state         00 MENU, 01 SETTING, 10 GAME
//   cursor        frame-aligned cursor (0 START, 1 SETTING)
//   highlight_on  frame-aligned blink phase of the selected item
//   difficulty    frame-aligned difficulty 0..3
//   start_game    one-cycle pulse in the first cycle state reads GAME
//
// state    | meaning
// ---------+----------------------------------------------
// ST_MENU    | main menu, cursor moves, item blinks
// ST_SETTING | difficulty adjust
// ST_GAME    | game running, waits for back / game_over
// ---------------------------------------------------------------------------
module menu_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned BLINK_FRAMES    = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic       btn_back,
    input  logic       game_over,
    output logic [1:0] state,
    output logic       cursor,
    output logic       highlight_on,
    output logic [1:0] difficulty,
    output logic       start_game
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DB_TC = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FR_TC = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_MENU    = 2'b00,
        ST_SETTING = 2'b01,
        ST_GAME    = 2'b10
    } state_e;

    // bit order: 0 up, 1 down, 2 sel, 3 back
    logic [3:0]    btn_raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    level_q;
    logic [3:0]    press_q;
    logic [DW-1:0] db_cnt_q [4];

    state_e        state_q, state_d;
    logic          cur_w_q, cur_w_d;
    logic [1:0]    diff_w_q, diff_w_d;
    logic          cursor_q;
    logic [1:0]    diff_q;
    logic [FW-1:0] fcnt_q;
    logic          hl_q;
    logic          restart_q;
    logic          start_q;

    logic ev_up, ev_down, ev_sel, ev_back;
    logic cur_chg, menu_entry, restart;

    assign btn_raw = {btn_back, btn_sel, btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            press_q <= '0;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (db_cnt_q[i] == DB_TC) begin
                        level_q[i]  <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                        // only the rising accepted level is an event
                        press_q[i]  <= sync2_q[i];
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // back > sel > up/down; up and down together cancel
    always_comb begin
        ev_back = press_q[3];
        ev_sel  = press_q[2] & ~press_q[3];
        ev_up   = press_q[0] & ~press_q[1] & ~press_q[2] & ~press_q[3];
        ev_down = press_q[1] & ~press_q[0] & ~press_q[2] & ~press_q[3];
    end

    always_comb begin
        state_d  = state_q;
        cur_w_d  = cur_w_q;
        diff_w_d = diff_w_q;
        case (state_q)
            ST_MENU: begin
                if (ev_sel) begin
                    state_d = cur_w_q ? ST_SETTING : ST_GAME;
                end else if (ev_up || ev_down) begin
                    cur_w_d = ~cur_w_q;
                end
            end
            ST_SETTING: begin
                if (ev_back || ev_sel) begin
                    state_d = ST_MENU;
                    cur_w_d = 1'b1;
                end else if (ev_up && diff_w_q != 2'd3) begin
                    diff_w_d = diff_w_q + 2'd1;
                end else if (ev_down && diff_w_q != 2'd0) begin
                    diff_w_d = diff_w_q - 2'd1;
                end
            end
            ST_GAME: begin
                if (ev_back || game_over) begin
                    state_d = ST_MENU;
                    cur_w_d = 1'b0;
                end
            end
            default: state_d = ST_MENU;
        endcase
    end

    assign cur_chg    = (cur_w_d != cur_w_q);
    assign menu_entry = (state_d == ST_MENU) && (state_q != ST_MENU);
    // a cursor move coinciding with frame_tick restarts the blink on that tick
    assign restart    = restart_q | cur_chg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_MENU;
            cur_w_q   <= 1'b0;
            diff_w_q  <= 2'd0;
            cursor_q  <= 1'b0;
            diff_q    <= 2'd0;
            fcnt_q    <= '0;
            hl_q      <= 1'b1;
            restart_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_w_q  <= cur_w_d;
            diff_w_q <= diff_w_d;
            start_q  <= (state_d == ST_GAME) && (state_q != ST_GAME);
            if (frame_tick) begin
                cursor_q  <= cur_w_d;
                diff_q    <= diff_w_d;
                restart_q <= 1'b0;
                if (restart) begin
                    fcnt_q <= '0;
                    hl_q   <= 1'b1;
                end else if (fcnt_q == FR_TC) begin
                    fcnt_q <= '0;
                    hl_q   <= ~hl_q;
                end else begin
                    fcnt_q <= fcnt_q + FW'(1);
                end
            end else begin
                restart_q <= restart;
            end
            if (menu_entry) begin
                fcnt_q <= '0;
                hl_q   <= 1'b1;
            end
        end
    end

    assign state        = state_q;
    assign cursor       = cursor_q;
    assign difficulty   = diff_q;
    assign highlight_on = hl_q & (state_q == ST_MENU);
    assign start_game   = start_q;

endmodule

// File: tb/tb_menu_controller.sv
module tb_menu_controller;
    localparam int DEB = 4;
    localparam int BF  = 2;

    logic clk = 1'b0;
    logic rst, frame_tick, btn_up, btn_down, btn_sel, btn_back, game_over;
    logic [1:0] state, difficulty;
    logic cursor, highlight_on, start_game;

    always #5 clk = ~clk;

    menu_controller #(.DEBOUNCE_CYCLES(DEB), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel), .btn_back(btn_back),
        .game_over(game_over), .state(state), .cursor(cursor),
        .highlight_on(highlight_on), .difficulty(difficulty), .start_game(start_game)
    );

    int ncmp = 0;
    int nmis = 0;

    // reference model: states 0 MENU, 1 SETTING, 2 GAME
    int m_state, m_cur_w, m_diff_w, m_cur, m_diff, m_k;
    bit m_pend;
    int exp_starts = 0;
    int seen_starts = 0;
    logic [1:0] prev_state = 2'b00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (start_game === 1'b1) begin
            seen_starts++;
            check("start_in_game", {6'b0, state}, 8'd2);
            check("start_first_cycle", {7'b0, prev_state != 2'b10}, 8'd1);
        end
        prev_state = state;
    endtask

    function automatic int m_hl();
        return (m_state == 0 && ((m_k / BF) % 2) == 0) ? 1 : 0;
    endfunction

    task automatic m_reset();
        m_state = 0; m_cur_w = 0; m_diff_w = 0; m_cur = 0; m_diff = 0;
        m_k = 0; m_pend = 0;
    endtask

    task automatic m_event(input int mask);
        bit up, dn, sel, bk;
        up = mask[0]; dn = mask[1]; sel = mask[2]; bk = mask[3];
        case (m_state)
            0: begin
                if (bk) begin
                end else if (sel) begin
                    if (m_cur_w == 0) begin m_state = 2; exp_starts++; end
                    else m_state = 1;
                end else if (up != dn) begin
                    m_cur_w = 1 - m_cur_w;
                    m_pend = 1;
                end
            end
            1: begin
                if (bk || sel) begin
                    m_state = 0; m_cur_w = 1; m_k = 0;
                end else if (up && !dn) begin
                    if (m_diff_w < 3) m_diff_w++;
                end else if (dn && !up) begin
                    if (m_diff_w > 0) m_diff_w--;
                end
            end
            default: begin
                if (bk) begin m_state = 0; m_cur_w = 0; m_k = 0; end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, {6'b0, state}, 8'(m_state));
        check({tag, "_cursor"}, {7'b0, cursor}, 8'(m_cur));
        check({tag, "_diff"}, {6'b0, difficulty}, 8'(m_diff));
        check({tag, "_hl"}, {7'b0, highlight_on}, 8'(m_hl()));
    endtask

    task automatic press(input int mask);
        btn_up = mask[0]; btn_down = mask[1]; btn_sel = mask[2]; btn_back = mask[3];
        repeat (DEB + 6) step();
        btn_up = 0; btn_down = 0; btn_sel = 0; btn_back = 0;
        repeat (DEB + 6) step();
        m_event(mask);
        check_all("press");
        check("starts", 8'(seen_starts), 8'(exp_starts));
    endtask

    task automatic frame();
        frame_tick = 1;
        step();
        frame_tick = 0;
        m_cur = m_cur_w; m_diff = m_diff_w;
        if (m_pend) begin m_k = 0; m_pend = 0; end
        else m_k++;
        check_all("frame");
        step();
    endtask

    task automatic gover();
        game_over = 1;
        step();
        game_over = 0;
        if (m_state == 2) begin m_state = 0; m_cur_w = 0; m_k = 0; end
        check("gover_latency", {6'b0, state}, 8'(m_state));
        check_all("gover");
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, {6'b0, state}, 8'd0);
        check({tag, "_cursor"}, {7'b0, cursor}, 8'd0);
        check({tag, "_diff"}, {6'b0, difficulty}, 8'd0);
        check({tag, "_hl"}, {7'b0, highlight_on}, 8'd1);
        check({tag, "_start"}, {7'b0, start_game}, 8'd0);
    endtask

    bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int sel_masks [10] = '{1, 2, 4, 8, 3, 12, 1, 2, 4, 8};
        rst = 1; frame_tick = 0; game_over = 0;
        btn_up = 0; btn_down = 0; btn_sel = 0; btn_back = 0;
        m_reset();
        step(); step();
        check_reset_vals("reset");
        rst = 0;
        step();

        // single down press, cursor only moves on frame_tick
        press(2);
        check("down_before_tick", {7'b0, cursor}, 8'd0);
        frame();
        check("down_after_tick", {7'b0, cursor}, 8'd1);
        check("down_hl", {7'b0, highlight_on}, 8'd1);

        // back to cursor 0, then a short glitch must not register
        press(1);
        frame();
        btn_down = 1;
        repeat (3) step();
        btn_down = 0;
        repeat (DEB + 8) step();
        frame();
        check("glitch_cursor", {7'b0, cursor}, 8'd0);

        // blink pattern from a clean reset
        rst = 1; step(); rst = 0; step(); m_reset();
        for (int i = 0; i < 6; i++) begin
            check("blink_seq", {7'b0, highlight_on}, {7'b0, pat[i]});
            frame();
        end

        // start game, then game_over
        press(4);
        check("game_state", {6'b0, state}, 8'd2);
        check("game_hl_off", {7'b0, highlight_on}, 8'd0);
        gover();
        frame();
        check("gover_cursor", {7'b0, cursor}, 8'd0);

        // up and down together are ignored
        press(3);
        frame();
        check("updown_cursor", {7'b0, cursor}, 8'd0);

        // settings: saturate up and down, then leave with back
        press(1);
        press(4);
        check("setting_state", {6'b0, state}, 8'd1);
        repeat (5) press(1);
        frame();
        check("diff_sat_hi", {6'b0, difficulty}, 8'd3);
        repeat (5) press(2);
        frame();
        check("diff_sat_lo", {6'b0, difficulty}, 8'd0);
        press(8);
        frame();
        check("back_cursor", {7'b0, cursor}, 8'd1);

        // sel and back together in SETTING give one return to MENU
        press(4);
        press(12);
        check("selback_state", {6'b0, state}, 8'd0);

        // reset mid-game
        press(1);
        press(4);
        check("game2_state", {6'b0, state}, 8'd2);
        rst = 1;
        step();
        check_reset_vals("rst_game");
        rst = 0;
        m_reset();
        step();

        // button held through reset yields exactly one press
        btn_up = 1;
        repeat (3) step();
        rst = 1; step(); step(); rst = 0;
        m_reset();
        m_event(1);
        repeat (DEB + 8) step();
        btn_up = 0;
        repeat (DEB + 6) step();
        frame();
        check("held_rst_cursor", {7'b0, cursor}, 8'd1);

        // randomized presses, game_over pulses and frames against the model
        for (int it = 0; it < 40; it++) begin
            press(sel_masks[$urandom_range(0, 9)]);
            if ($urandom_range(0, 3) == 0) gover();
            for (int f = 0; f < int'($urandom_range(0, 3)); f++) frame();
        end
        frame();
        check("final_starts", 8'(seen_starts), 8'(exp_starts));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end
endmodule
